keypad_scanner_db: RTL and testbench

- Parametrised matrix-keypad scanner for the calculator front end. Generalised to ROWS x COLS.
- Adds per-key debounce, press/release tracking and a valid/ready key-event output with a one-entry holding register and overrun flag.
- Sits between the board keypad pins and the calculator input FSM.
- Key code is the raw matrix index. Translation to calculator key values happens downstream via a package lookup table.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_evt_reg.sv | 62 ++++++
 rtl/keypad_scanner_db.sv | 223 ++++++++++++++++++++++
 tb/tb_keypad_scanner_db.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
// Contents:
//   state_e     - scanner FSM states.
//   key_width() - key code width for a ROWS x COLS matrix (minimum 1 bit).
//   CALC_LUT    - raw matrix index to calculator key value, used downstream.
//   calc_value()- lookup helper over CALC_LUT.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE_P = 2'd1,
    PRESSED    = 2'd2
  } state_e;

  // Bits needed to hold a key index 0..rows*cols-1; never narrower than 1.
  function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
    int unsigned n;
    n = rows * cols;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CALC_LUT_N = 16;

  localparam logic [3:0] CALC_LUT [CALC_LUT_N] = '{
    4'd1,  4'd2, 4'd3,  4'd12,
    4'd4,  4'd5, 4'd6,  4'd13,
    4'd7,  4'd8, 4'd9,  4'd14,
    4'd11, 4'd0, 4'd10, 4'd15
  };

  function automatic logic [3:0] calc_value(input logic [3:0] idx);
    return CALC_LUT[idx];
  endfunction

endpackage

// File: rtl/keypad_evt_reg.sv
// One-entry valid/ready holding register for key events, with a sticky
// overrun flag.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   push_c        - a new event is offered this cycle
//   push_code     - code of the offered event
//   ready         - consumer accepts when valid & ready
//   valid, code   - pending event (code stable while valid)
//   overrun       - sticky: an event was dropped because the slot was full
module keypad_evt_reg #(
  parameter int unsigned KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_c,
  input  logic [KEY_W-1:0] push_code,
  input  logic             ready,
  output logic             valid,
  output logic [KEY_W-1:0] code,
  output logic             overrun
);

  logic             valid_q, valid_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             overrun_q, overrun_d;
  logic             hs_c;

  // Slot is free if empty or being drained in the same cycle.
  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = overrun_q;
    hs_c      = valid_q & ready;
    if (push_c) begin
      if (!valid_q || hs_c) begin
        valid_d = 1'b1;
        code_d  = push_code;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (hs_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign code    = code_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/keypad_scanner_db.sv
// ROWS x COLS matrix keypad scanner with per-key debounce, press/release
// tracking and a valid/ready key-event output.
// Ports:
//   CLK, RESET   - clock, async active-low reset
//   keyboardfil  - row sense lines (active-high, pre-synchronised)
//   keyboardcol  - one-hot column drive
//   key_code     - row*COLS+col of the accepted key, valid with key_valid
//   key_valid    - event pending; key_ready accepts it
//   key_held     - high from press acceptance to release acceptance
//   overrun      - sticky, a press was dropped while an event was pending
// Optional: define KEYPAD_REPEAT_EN for auto-repeat events while a key is
// held (REPEAT_DLY samples to first repeat, then every REPEAT_RATE samples).
module keypad_scanner_db
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY  = 64,
  parameter int unsigned REPEAT_RATE = 16
`endif
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [ROWS-1:0]                     keyboardfil,
  output logic [COLS-1:0]                     keyboardcol,
  output logic [key_width(ROWS, COLS)-1:0]    key_code,
  output logic                                key_valid,
  input  logic                                key_ready,
  output logic                                key_held,
  output logic                                overrun
);

  localparam int unsigned KEY_W   = key_width(ROWS, COLS);
  localparam int unsigned ROW_W   = key_width(ROWS, 1);
  localparam int unsigned COL_W   = key_width(COLS, 1);
  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
`endif

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [COLS-1:0]    col_oh_q, col_oh_d;
  logic [KEY_W-1:0]   cand_q, cand_d;
  logic [ROW_W-1:0]   cand_row_q, cand_row_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [DEB_W-1:0]   rel_q, rel_d;
  logic               held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [RPT_W-1:0]   rpt_q, rpt_d;
  logic               rpt_first_q, rpt_first_d;
  logic [RPT_W-1:0]   rpt_last_c;
`endif

  logic               sample_c;
  logic               hit_c;
  logic [ROW_W-1:0]   row_c;
  logic [KEY_W-1:0]   code_c;
  logic               accept_c;
  logic               advance_c;
  logic               push_c;

  // Lowest-index active row and the matrix code it maps to.
  always_comb begin
    row_c = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (keyboardfil[i]) row_c = ROW_W'(i);
    end
    hit_c  = |keyboardfil;
    code_c = KEY_W'(row_c) * KEY_W'(COLS) + KEY_W'(col_q);
  end

  // Scanner FSM: next state, counters and column drive.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    col_oh_d   = col_oh_q;
    cand_d     = cand_q;
    cand_row_d = cand_row_q;
    deb_d      = deb_q;
    rel_d      = rel_q;
    held_d     = held_q;
    accept_c   = 1'b0;
    advance_c  = 1'b0;
    push_c     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_last_c  = rpt_first_q ? RPT_W'(REPEAT_DLY - 1) : RPT_W'(REPEAT_RATE - 1);
`endif

    sample_c = (dwell_q == DWELL_LAST);
    dwell_d  = sample_c ? '0 : dwell_q + 1'b1;

    if (sample_c) begin
      unique case (state_q)
        SCAN: begin
          if (hit_c) begin
            cand_d     = code_c;
            cand_row_d = row_c;
            if (DEBOUNCE == 1) begin
              accept_c = 1'b1;
            end else begin
              deb_d   = DEB_W'(1);
              state_d = DEBOUNCE_P;
            end
          end else begin
            advance_c = 1'b1;
          end
        end
        DEBOUNCE_P: begin
          if (hit_c && (code_c == cand_q)) begin
            if (deb_q == DEB_LAST) accept_c = 1'b1;
            else                   deb_d    = deb_q + 1'b1;
          end else begin
            state_d   = SCAN;
            advance_c = 1'b1;
          end
        end
        PRESSED: begin
          // Only the tracked key's row matters; the column is still frozen on it.
          if (!keyboardfil[cand_row_q]) begin
            if (rel_q == DEB_LAST) begin
              state_d   = SCAN;
              held_d    = 1'b0;
              advance_c = 1'b1;
            end else begin
              rel_d = rel_q + 1'b1;
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (state_d == PRESSED) begin
            if (rpt_q == rpt_last_c) begin
              push_c      = 1'b1;
              rpt_d       = '0;
              rpt_first_d = 1'b0;
            end else begin
              rpt_d = rpt_q + 1'b1;
            end
          end
`endif
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept_c) begin
      state_d = PRESSED;
      held_d  = 1'b1;
      rel_d   = '0;
      push_c  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rpt_d       = '0;
      rpt_first_d = 1'b1;
`endif
    end

    if (advance_c) begin
      col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
    col_oh_d = COLS'(1) << col_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= SCAN;
      dwell_q    <= '0;
      col_q      <= '0;
      col_oh_q   <= COLS'(1);
      cand_q     <= '0;
      cand_row_q <= '0;
      deb_q      <= '0;
      rel_q      <= '0;
      held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_oh_q   <= col_oh_d;
      cand_q     <= cand_d;
      cand_row_q <= cand_row_d;
      deb_q      <= deb_d;
      rel_q      <= rel_d;
      held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  keypad_evt_reg #(
    .KEY_W (KEY_W)
  ) u_evt (
    .clk       (CLK),
    .rst_n     (RESET),
    .push_c    (push_c),
    .push_code (cand_d),
    .ready     (key_ready),
    .valid     (key_valid),
    .code      (key_code),
    .overrun   (overrun)
  );

  assign keyboardcol = col_oh_q;
  assign key_held    = held_q;

endmodule

// File: tb/tb_keypad_scanner_db.sv
// Bench for keypad_scanner_db (4x4, SCAN_DIV=4, DEBOUNCE=3). A board model
// closes pressed-key contacts between driven columns and sensed rows; a
// sample-level behavioural model predicts every output each cycle.
module tb_keypad_scanner_db;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SDIV = 4;
  localparam int DEB  = 3;

  logic       CLK;
  logic       RESET;
  logic [3:0] keyboardfil;
  logic [3:0] keyboardcol;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  logic [3:0][3:0] keys;   // keys[row][col] = contact closed

  int n_chk = 0;
  int n_err = 0;
  int valid_seen;
  int last_code;

  // Model: phase 0 = scanning, 1 = confirming press, 2 = holding.
  int m_col, m_dwell, m_phase, m_cand, m_cnt, m_code;
  bit m_valid, m_held, m_over;

  keypad_scanner_db #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .keyboardfil (keyboardfil),
    .keyboardcol (keyboardcol),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .overrun     (overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) keyboardfil[r] = |(keys[r] & keyboardcol);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_row(input int col);
    for (int r = 0; r < ROWS; r++) if (keys[r][col]) return r;
    return -1;
  endfunction

  task automatic model_reset();
    m_col = 0; m_dwell = 0; m_phase = 0; m_cand = 0; m_cnt = 0;
    m_code = 0; m_valid = 0; m_held = 0; m_over = 0;
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic model_step();
    bit push;
    bit hs;
    bit take;
    int r;
    push = 0;
    take = 0;
    hs = m_valid && key_ready;
    if (m_dwell == SDIV - 1) begin
      r = low_row(m_col);
      if (m_phase == 0) begin
        if (r >= 0) begin
          m_cand = r * COLS + m_col;
          m_cnt = 1;
          if (m_cnt >= DEB) take = 1; else m_phase = 1;
        end else m_col = (m_col + 1) % COLS;
      end else if (m_phase == 1) begin
        if (r >= 0 && r * COLS + m_col == m_cand) begin
          m_cnt++;
          if (m_cnt == DEB) take = 1;
        end else begin
          m_phase = 0;
          m_col = (m_col + 1) % COLS;
        end
      end else begin
        if (!keys[m_cand / COLS][m_cand % COLS]) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_phase = 0;
            m_held = 0;
            m_col = (m_col + 1) % COLS;
          end
        end else m_cnt = 0;
      end
    end
    if (take) begin
      m_phase = 2; m_cnt = 0; m_held = 1; push = 1;
    end
    m_dwell = (m_dwell + 1) % SDIV;
    if (push) begin
      if (!m_valid || hs) begin
        m_valid = 1;
        m_code = m_cand;
      end else m_over = 1;
    end else if (hs) m_valid = 0;
  endtask

  task automatic compare_all();
    chk("col", 32'(keyboardcol), 32'(1 << m_col));
    chk("valid", 32'(key_valid), 32'(m_valid));
    chk("held", 32'(key_held), 32'(m_held));
    chk("overrun", 32'(overrun), 32'(m_over));
    if (m_valid) chk("code", 32'(key_code), 32'(m_code));
    if (key_valid === 1'b1) begin
      valid_seen++;
      last_code = int'(key_code);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge CLK);
      #1;
      compare_all();
    end
  endtask

  task automatic wait_col(input logic [3:0] target);
    int k;
    k = 0;
    while (keyboardcol !== target && k < 64) begin
      cyc(1);
      k++;
    end
    chk("wait_col", 32'(keyboardcol), 32'(target));
  endtask

  task automatic wait_release();
    int k;
    k = 0;
    while (key_held !== 1'b0 && k < 64) begin
      cyc(1);
      k++;
    end
    chk("release_seen", 32'(key_held), 32'd0);
  endtask

  // Async reset mid-cycle: outputs must return to reset values before any edge.
  task automatic do_reset();
    #2 RESET = 1'b0;
    #1;
    chk("rst_col", 32'(keyboardcol), 32'h1);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  initial begin
    int rr, cc, hold;
    RESET = 1'b1;
    keys = '0;
    key_ready = 1'b1;
    do_reset();

    // Idle scan.
    cyc(32);

    // Single press of code 6 (row1, col2) with consumer ready.
    keys[1][2] = 1'b1;
    valid_seen = 0;
    cyc(40);
    chk("p6_held", 32'(key_held), 32'h1);
    chk("p6_col", 32'(keyboardcol), 32'h4);
    chk("p6_code", 32'(last_code), 32'd6);
    chk("p6_pulse", 32'(valid_seen), 32'd1);
    keys = '0;
    wait_release();
    chk("p6_resume_col", 32'(keyboardcol), 32'h8);

    // Bouncing contact on row1/col2: no event, scan moves on.
    wait_col(4'b0010);
    wait_col(4'b0100);
    valid_seen = 0;
    keys[1][2] = 1'b1;
    cyc(SDIV);
    keys = '0;
    cyc(SDIV);
    chk("bounce_col", 32'(keyboardcol), 32'h8);
    keys[1][2] = 1'b1;
    cyc(SDIV);
    keys = '0;
    cyc(2 * SDIV);
    chk("bounce_no_evt", 32'(valid_seen), 32'd0);

    // Overrun: second press while the first event is still pending.
    key_ready = 1'b0;
    keys[1][2] = 1'b1;
    cyc(40);
    keys = '0;
    cyc(20);
    keys[2][1] = 1'b1;
    cyc(40);
    chk("ovr_valid", 32'(key_valid), 32'h1);
    chk("ovr_code", 32'(key_code), 32'd6);
    chk("ovr_flag", 32'(overrun), 32'h1);
    keys = '0;
    cyc(20);
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
    chk("ovr_drain", 32'(key_valid), 32'h0);
    cyc(4);

    // Rows 0 and 3 together on col1: lowest row wins.
    key_ready = 1'b1;
    keys[0][1] = 1'b1;
    keys[3][1] = 1'b1;
    valid_seen = 0;
    cyc(40);
    chk("multi_code", 32'(last_code), 32'd1);
    keys = '0;
    cyc(20);

    // Random presses, random consumer backpressure.
    for (int t = 0; t < 40; t++) begin
      keys = '0;
      rr = int'($urandom_range(0, 3));
      cc = int'($urandom_range(0, 3));
      keys[rr][cc] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rr = int'($urandom_range(0, 3));
        cc = int'($urandom_range(0, 3));
        keys[rr][cc] = 1'b1;
      end
      hold = int'($urandom_range(2, 40));
      for (int h = 0; h < hold; h++) begin
        key_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
      keys = '0;
      hold = int'($urandom_range(0, 30));
      for (int h = 0; h < hold; h++) begin
        key_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
    end

    // Reset while PRESSED with an event pending.
    key_ready = 1'b0;
    cyc(30);
    key_ready = 1'b1;
    cyc(2);
    key_ready = 1'b0;
    keys = '0;
    keys[2][3] = 1'b1;
    cyc(40);
    chk("pre_rst_held", 32'(key_held), 32'h1);
    chk("pre_rst_valid", 32'(key_valid), 32'h1);
    do_reset();
    keys = '0;
    key_ready = 1'b1;
    cyc(16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
